video_ula: RTL and testbench

VIDEO_ULA -- requirements
Module: video_ula

---
 rtl/video_ula_pkg.sv | 31 +++
 rtl/video_ula_palette.sv | 29 ++
 rtl/video_ula.sv | 127 ++++++++++++
 tb/tb_video_ula.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/video_ula_pkg.sv
// Shared definitions for video_ula: CTRL field layout, register-select codes, pixel-rate table.
// The optional cursor overlay is selected with the VIDEO_ULA_CURSOR_EN macro (see video_ula.sv).
package video_ula_pkg;

  typedef struct packed {
    logic [2:0] cur_seg;  // [7]=segment 0, [6]=segment 1, [5]=segments 2-3
    logic       fast;
    logic [1:0] rate;
    logic       rsvd;
    logic       flash;
  } ctrl_t;

  localparam logic REG_SEL_CTRL    = 1'b0;
  localparam logic REG_SEL_PALETTE = 1'b1;

  localparam int unsigned PAL_DEPTH = 16;
  localparam int unsigned PAL_W     = 4;

  // Phase bits that must be zero for a shift: every 8/4/2/1 cycles.
  function automatic logic [2:0] shift_mask(input logic [1:0] rate);
    logic [2:0] mask;
    case (rate)
      2'b00:   mask = 3'b111;
      2'b01:   mask = 3'b011;
      2'b10:   mask = 3'b001;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/video_ula_palette.sv
// 16x4 logical-to-physical colour palette: one synchronous write port, one combinational read port.
module ula_palette
  import video_ula_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [3:0]           wr_idx,
  input  logic [PAL_W-1:0]     wr_data,
  input  logic [3:0]           rd_idx,
  output logic [PAL_W-1:0]     rd_data
);

  logic [PAL_W-1:0] pal_q [PAL_DEPTH];
  logic [PAL_W-1:0] pal_d [PAL_DEPTH];

  always_comb begin
    pal_d = pal_q;
    if (we) pal_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) pal_q <= '{default: '0};
    else     pal_q <= pal_d;
  end

  assign rd_data = pal_q[rd_idx];

endmodule

// File: rtl/video_ula.sv
// Video ULA: character strobe generation, pixel shifter, palette lookup and RGB output stage.
// Define VIDEO_ULA_CURSOR_EN to build the segmented cursor overlay; otherwise CURSOR is ignored.
module video_ula
  import video_ula_pkg::*;
(
  input  logic       PIXELCLK,
  input  logic       RESET,
  input  logic       PROC_en,
  input  logic       nCS,
  input  logic       A0,
  input  logic [7:0] DATABUS,
  input  logic [7:0] FRAMESTORE_DATA,
  input  logic       DISEN,
  input  logic       CURSOR,
  output logic       CRTC_en,
  output logic [2:0] RGB
);

  ctrl_t      ctrl_q, ctrl_d;
  logic [3:0] phase_q, phase_d;
  logic       crtc_en_q, crtc_en_d;
  logic [7:0] sr_q, sr_d;
  logic       dis_q, dis_d;
  logic [2:0] rgb_q, rgb_d;

  logic       ctrl_we, pal_we, shift_en, cur_xor, unused_bits;
  logic [3:0] logical_idx, phys;
  logic [2:0] colour, pixel;

  assign ctrl_we = ~nCS & PROC_en & (A0 == REG_SEL_CTRL);
  assign pal_we  = ~nCS & PROC_en & (A0 == REG_SEL_PALETTE);

  ula_palette u_palette (
    .clk     (PIXELCLK),
    .rst     (RESET),
    .we      (pal_we),
    .wr_idx  (DATABUS[7:4]),
    .wr_data (DATABUS[3:0]),
    .rd_idx  (logical_idx),
    .rd_data (phys)
  );

  // The load cycle (strobe just seen) always wins over a shift.
  assign shift_en    = ~crtc_en_q & ((phase_q[2:0] & shift_mask(ctrl_q.rate)) == 3'b000);
  assign logical_idx = {sr_q[7], sr_q[5], sr_q[3], sr_q[1]};
  assign colour      = (phys[3] & ctrl_q.flash) ? ~phys[2:0] : phys[2:0];
  assign pixel       = dis_q ? colour : 3'b000;

  always_comb begin
    ctrl_d    = ctrl_we ? ctrl_t'(DATABUS) : ctrl_q;
    phase_d   = phase_q + 4'd1;
    crtc_en_d = ctrl_q.fast ? (phase_q[2:0] == 3'd7) : (phase_q == 4'd15);
    sr_d      = sr_q;
    dis_d     = dis_q;
    if (crtc_en_q) begin
      sr_d  = FRAMESTORE_DATA;
      dis_d = DISEN;
    end else if (shift_en) begin
      sr_d = {sr_q[6:0], 1'b1};
    end
    rgb_d = pixel ^ {3{cur_xor}};
  end

  always_ff @(posedge PIXELCLK) begin
    if (RESET) begin
      ctrl_q    <= '0;
      phase_q   <= '0;
      crtc_en_q <= 1'b0;
      sr_q      <= '0;
      dis_q     <= 1'b0;
      rgb_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      phase_q   <= phase_d;
      crtc_en_q <= crtc_en_d;
      sr_q      <= sr_d;
      dis_q     <= dis_d;
      rgb_q     <= rgb_d;
    end
  end

`ifdef VIDEO_ULA_CURSOR_EN
  logic       cur_q, cur_d;
  logic       cur_act_q, cur_act_d;
  logic [1:0] seg_q, seg_d;

  // A rising cursor flag at a load starts segment 0; each later load advances one segment.
  always_comb begin
    cur_d     = cur_q;
    cur_act_d = cur_act_q;
    seg_d     = seg_q;
    if (crtc_en_q) begin
      cur_d = CURSOR;
      if (CURSOR & ~cur_q) begin
        cur_act_d = 1'b1;
        seg_d     = 2'd0;
      end else if (cur_act_q) begin
        if (seg_q == 2'd3) cur_act_d = 1'b0;
        seg_d = seg_q + 2'd1;
      end
    end
  end

  always_ff @(posedge PIXELCLK) begin
    if (RESET) begin
      cur_q     <= 1'b0;
      cur_act_q <= 1'b0;
      seg_q     <= '0;
    end else begin
      cur_q     <= cur_d;
      cur_act_q <= cur_act_d;
      seg_q     <= seg_d;
    end
  end

  assign cur_xor = cur_act_q & ((seg_q == 2'd0) ? ctrl_q.cur_seg[2] :
                                (seg_q == 2'd1) ? ctrl_q.cur_seg[1] : ctrl_q.cur_seg[0]);
  assign unused_bits = ctrl_q.rsvd;
`else
  assign cur_xor     = 1'b0;
  assign unused_bits = ^{CURSOR, ctrl_q.cur_seg, ctrl_q.rsvd};
`endif

  assign CRTC_en = crtc_en_q;
  assign RGB     = rgb_q;

endmodule

// File: tb/tb_video_ula.sv
// Directed bench for video_ula: table of palette/CTRL/data vectors plus hand-written timing sequences.
module tb_video_ula;

  logic       PIXELCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PROC_en = 1'b0;
  logic       nCS = 1'b1;
  logic       A0 = 1'b0;
  logic [7:0] DATABUS = '0;
  logic [7:0] FRAMESTORE_DATA = '0;
  logic       DISEN = 1'b0;
  logic       CURSOR = 1'b0;
  logic       CRTC_en;
  logic [2:0] RGB;

  int vec_cnt = 0;
  int err_cnt = 0;

  video_ula dut (
    .PIXELCLK        (PIXELCLK),
    .RESET           (RESET),
    .PROC_en         (PROC_en),
    .nCS             (nCS),
    .A0              (A0),
    .DATABUS         (DATABUS),
    .FRAMESTORE_DATA (FRAMESTORE_DATA),
    .DISEN           (DISEN),
    .CURSOR          (CURSOR),
    .CRTC_en         (CRTC_en),
    .RGB             (RGB)
  );

  always #5 PIXELCLK = ~PIXELCLK;

  typedef struct {
    logic [7:0] ctrl;
    logic [3:0] idx;
    logic [3:0] val;
    logic [7:0] data;
    logic       disen;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge PIXELCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic a0, input logic [7:0] d);
    nCS = 1'b0; PROC_en = 1'b1; A0 = a0; DATABUS = d;
    step();
    nCS = 1'b1; PROC_en = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  // Returns with CRTC_en high, so the next edge is the load edge.
  task automatic wait_crtc(input string name);
    for (int i = 0; i < 40; i++) begin
      if (CRTC_en === 1'b1) return;
      step();
    end
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: CRTC_en never pulsed within 40 cycles", name);
  endtask

  initial begin
    logic [2:0] seq_exp [8];
    logic [2:0] cur_first;

    // ctrl, palette idx, palette value, framestore byte, DISEN, expected RGB (fast, rate 00: held 8 pixels)
    vecs[0] = '{8'h10, 4'hF, 4'h7, 8'hAA, 1'b1, 3'd7};
    vecs[1] = '{8'h10, 4'h0, 4'h5, 8'h00, 1'b1, 3'd5};
    vecs[2] = '{8'h11, 4'hF, 4'h9, 8'hAA, 1'b1, 3'd6};
    vecs[3] = '{8'h10, 4'hF, 4'h9, 8'hAA, 1'b1, 3'd1};
    vecs[4] = '{8'h11, 4'h5, 4'h4, 8'h22, 1'b1, 3'd4};
    vecs[5] = '{8'h11, 4'hA, 4'hE, 8'h88, 1'b1, 3'd1};
    vecs[6] = '{8'h10, 4'h3, 4'h6, 8'h0A, 1'b0, 3'd0};
    vecs[7] = '{8'h12, 4'h0, 4'h3, 8'h00, 1'b1, 3'd3};
    vecs[8] = '{8'h10, 4'hC, 4'h2, 8'hA0, 1'b1, 3'd2};

    // Reset state and fast-mode strobe cadence
    do_reset();
    chk("reset_rgb", RGB, 3'd0);
    chk("reset_crtc_en", {2'b00, CRTC_en}, 3'd0);
    wr(1'b0, 8'h10);
    chk("fast_crtc_en_e1", {2'b00, CRTC_en}, 3'd0);
    for (int k = 2; k <= 24; k++) begin
      step();
      chk($sformatf("fast_crtc_en_e%0d", k), {2'b00, CRTC_en}, {2'b00, (k % 8) == 0});
    end

    // Table vectors: whole character checked
    for (int v = 0; v < 9; v++) begin
      wr(1'b0, vecs[v].ctrl);
      wr(1'b1, {vecs[v].idx, vecs[v].val});
      FRAMESTORE_DATA = vecs[v].data;
      DISEN = vecs[v].disen;
      wait_crtc($sformatf("vec%0d_wait", v));
      step();
      for (int c = 0; c < 8; c++) begin
        step();
        chk($sformatf("vec%0d_px%0d", v, c), RGB, vecs[v].exp);
      end
    end

    // Flash inversion then clearing FLASH
    wr(1'b0, 8'h11);
    wr(1'b1, 8'hF9);
    FRAMESTORE_DATA = 8'hAA;
    DISEN = 1'b1;
    wait_crtc("flash_wait");
    step();
    step();
    chk("flash_on", RGB, 3'b110);
    wr(1'b0, 8'h10);
    step();
    chk("flash_off_2edges", RGB, 3'b001);

    // Fastest pixel rate alternating pattern
    do_reset();
    wr(1'b0, 8'h1C);
    wr(1'b1, 8'hF7);
    wr(1'b1, 8'h00);
    FRAMESTORE_DATA = 8'hAA;
    DISEN = 1'b1;
    seq_exp = '{3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 3'd0};
    wait_crtc("rate3_wait");
    step();
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("rate3_px%0d", c), RGB, seq_exp[c]);
    end

    // Cursor segment 0 only (plain build: cursor ignored)
`ifdef VIDEO_ULA_CURSOR_EN
    cur_first = 3'b101;
`else
    cur_first = 3'b010;
`endif
    do_reset();
    wr(1'b0, 8'h90);
    wr(1'b1, 8'h02);
    FRAMESTORE_DATA = 8'h00;
    DISEN = 1'b1;
    CURSOR = 1'b1;
    wait_crtc("cursor_wait");
    step();
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("cursor_seg0_px%0d", c), RGB, cur_first);
    end
    for (int c = 0; c < 24; c++) begin
      step();
      chk($sformatf("cursor_later_px%0d", c), RGB, 3'b010);
    end
    CURSOR = 1'b0;

    // Reset mid-byte, slow-mode first strobe, palette cleared
    step();
    step();
    RESET = 1'b1;
    step();
    chk("midreset_rgb", RGB, 3'd0);
    chk("midreset_crtc_en", {2'b00, CRTC_en}, 3'd0);
    step();
    RESET = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("release_crtc_en_e%0d", k), {2'b00, CRTC_en}, {2'b00, k == 16});
      chk($sformatf("release_rgb_e%0d", k), RGB, 3'd0);
    end
    wr(1'b0, 8'h10);
    wait_crtc("post_reset_wait");
    step();
    step();
    chk("post_reset_palette0", RGB, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
